// File: rtl/simon_core_n.sv
// simon_core_n -- parametrised Simon game controller.
// Plays back a growing random colour sequence, checks the player's answers,
// and reports WIN/LOSE together with the current score and a high score.
// Optional build macro SIMON_ECHO_EN: each correct press is echoed on the
// lamps for SHOW_TICKS cycles before the game moves on.
module simon_core_n #(
    parameter int NUM_COLORS    = 4,
    parameter int MAX_LEN       = 32,
    parameter int SHOW_TICKS    = 4000,
    parameter int GAP_TICKS     = 2000,
    parameter int TIMEOUT_TICKS = 50000,
    localparam int COLOR_W = ($clog2(NUM_COLORS) > 1) ? $clog2(NUM_COLORS) : 1,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START_GAME,
    input  logic [COLOR_W-1:0] IN,
    input  logic               IN_VALID,
    input  logic [COLOR_W-1:0] RAND,
    output logic [COLOR_W-1:0] OUT,
    output logic               OUT_ENA,
    output logic               LOSE,
    output logic               WIN,
    output logic               HS,
    output logic [LEN_W-1:0]   SCORE,
    output logic [LEN_W-1:0]   HISCORE
);

    // Memory address width: enough for indices 0..MAX_LEN-1.
    localparam int ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int MEM_D   = 2 ** ADDR_W;
    // One timer serves gap, show and input-timeout intervals.
    localparam int MAX_SG  = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int MAX_T   = (MAX_SG > TIMEOUT_TICKS) ? MAX_SG : TIMEOUT_TICKS;
    localparam int TIMER_W = $clog2(MAX_T + 1);

    localparam logic [COLOR_W:0]   NC_EXT    = (COLOR_W + 1)'(NUM_COLORS);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_TICKS - 1);
    localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(TIMEOUT_TICKS - 1);
    localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADD     = 3'd1,
        S_GAP     = 3'd2,
        S_SHOW    = 3'd3,
        S_WAIT_IN = 3'd4,
`ifdef SIMON_ECHO_EN
        S_ECHO    = 3'd5,
`endif
        S_LOSE    = 3'd6,
        S_WIN     = 3'd7
    } state_t;

    state_t             state_q, state_d, ok_next;
    logic               start_q;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [LEN_W-1:0]   score_q, score_d;
    logic [LEN_W-1:0]   hiscore_q, hiscore_d;
    logic               hs_q, hs_d;

    logic [COLOR_W-1:0] mem_q [MEM_D];
    logic               mem_we;
    logic [COLOR_W-1:0] mem_wdata;
    logic [COLOR_W-1:0] mem_rd;

    logic               start_edge;
    logic               last_idx;
    logic               in_ok;
    logic [COLOR_W-1:0] rand_fold;

`ifdef SIMON_ECHO_EN
    logic [COLOR_W-1:0] echo_col_q, echo_col_d;
    state_t             echo_ret_q, echo_ret_d;
    logic [TIMER_W-1:0] echo_cnt_q, echo_cnt_d;
`endif

    assign start_edge = START_GAME & ~start_q;
    assign mem_rd     = mem_q[idx_q[ADDR_W-1:0]];
    assign last_idx   = (idx_q == (len_q - LEN_W'(1)));
    // Out-of-range colours never match a stored entry.
    assign in_ok      = ({1'b0, IN} < NC_EXT) && (IN == mem_rd);
    // Out-of-range random values are folded back into the colour range.
    assign rand_fold  = ({1'b0, RAND} >= NC_EXT) ? (RAND - COLOR_W'(NUM_COLORS)) : RAND;

    // Next-state and datapath updates; a start edge overrides everything else.
    always_comb begin
        state_d   = state_q;
        ok_next   = S_WAIT_IN;
        len_d     = len_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        score_d   = score_q;
        hiscore_d = hiscore_q;
        hs_d      = hs_q;
        mem_we    = 1'b0;
        mem_wdata = rand_fold;
`ifdef SIMON_ECHO_EN
        echo_col_d = echo_col_q;
        echo_ret_d = echo_ret_q;
        echo_cnt_d = echo_cnt_q;
`endif
        if (start_edge) begin
            state_d = S_ADD;
            len_d   = '0;
            idx_d   = '0;
            timer_d = '0;
            score_d = '0;
            hs_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ADD: begin
                    mem_we  = 1'b1;
                    len_d   = len_q + LEN_W'(1);
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = S_GAP;
                end
                S_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        timer_d = '0;
                        state_d = S_SHOW;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                S_SHOW: begin
                    if (timer_q == SHOW_LAST) begin
                        timer_d = '0;
                        if (last_idx) begin
                            idx_d   = '0;
                            state_d = S_WAIT_IN;
                        end else begin
                            idx_d   = idx_q + LEN_W'(1);
                            state_d = S_GAP;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                S_WAIT_IN: begin
                    timer_d = timer_q + TIMER_W'(1);
                    if (IN_VALID) begin
                        timer_d = '0;
                        if (!in_ok) begin
                            state_d = S_LOSE;
                        end else begin
                            if (last_idx) begin
                                score_d = len_q;
                                ok_next = (len_q == LEN_MAX) ? S_WIN : S_ADD;
                            end else begin
                                idx_d   = idx_q + LEN_W'(1);
                                ok_next = S_WAIT_IN;
                            end
`ifdef SIMON_ECHO_EN
                            echo_col_d = IN;
                            echo_ret_d = ok_next;
                            echo_cnt_d = '0;
                            state_d    = S_ECHO;
`else
                            state_d    = ok_next;
`endif
                        end
                    end else if ((TIMEOUT_TICKS != 0) && (timer_q == TMO_LAST)) begin
                        state_d = S_LOSE;
                    end
                end
`ifdef SIMON_ECHO_EN
                S_ECHO: begin
                    timer_d = '0;
                    if (echo_cnt_q == SHOW_LAST) begin
                        state_d = echo_ret_q;
                    end else begin
                        echo_cnt_d = echo_cnt_q + TIMER_W'(1);
                    end
                end
`endif
                S_LOSE, S_WIN: ;
                default: state_d = S_IDLE;
            endcase
            // Entry into an end state: record a new high score once.
            if ((state_d == S_LOSE || state_d == S_WIN) &&
                (state_q != S_LOSE && state_q != S_WIN) &&
                (score_d > hiscore_q)) begin
                hiscore_d = score_d;
                hs_d      = 1'b1;
            end
        end
    end

    // Lamp and status outputs decoded from the registered state.
    always_comb begin
        OUT_ENA = 1'b0;
        OUT     = '0;
        if (state_q == S_SHOW) begin
            OUT_ENA = 1'b1;
            OUT     = mem_rd;
        end
`ifdef SIMON_ECHO_EN
        if (state_q == S_ECHO) begin
            OUT_ENA = 1'b1;
            OUT     = echo_col_q;
        end
`endif
        LOSE    = (state_q == S_LOSE);
        WIN     = (state_q == S_WIN);
        HS      = hs_q;
        SCORE   = score_q;
        HISCORE = hiscore_q;
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            len_q     <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            score_q   <= '0;
            hiscore_q <= '0;
            hs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= START_GAME;
            len_q     <= len_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            score_q   <= score_d;
            hiscore_q <= hiscore_d;
            hs_q      <= hs_d;
        end
    end

`ifdef SIMON_ECHO_EN
    // Echo colour, pending transition and echo duration counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            echo_col_q <= '0;
            echo_ret_q <= S_IDLE;
            echo_cnt_q <= '0;
        end else begin
            echo_col_q <= echo_col_d;
            echo_ret_q <= echo_ret_d;
            echo_cnt_q <= echo_cnt_d;
        end
    end
`endif

    // Sequence memory; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[len_q[ADDR_W-1:0]] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_simon_core_n.sv
// Testbench for simon_core_n (NUM_COLORS=4, MAX_LEN=3, SHOW=3, GAP=2, TIMEOUT=20).
// Expected lamp colours are queued as the random colours are driven and
// popped as each lamp flash appears.
module tb_simon_core_n;

    localparam int NC = 4;
    localparam int ML = 3;
    localparam int ST = 3;
    localparam int GT = 2;
    localparam int TT = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START_GAME = 1'b0;
    logic [1:0] IN = 2'd0;
    logic       IN_VALID = 1'b0;
    logic [1:0] RAND = 2'd0;
    logic [1:0] OUT;
    logic       OUT_ENA;
    logic       LOSE;
    logic       WIN;
    logic       HS;
    logic [1:0] SCORE;
    logic [1:0] HISCORE;

    int vectors = 0;
    int miscompares = 0;
    int game_seq[$];
    int exp_q[$];

    simon_core_n #(
        .NUM_COLORS(NC), .MAX_LEN(ML), .SHOW_TICKS(ST),
        .GAP_TICKS(GT), .TIMEOUT_TICKS(TT)
    ) dut (
        .CLK(CLK), .RST(RST), .START_GAME(START_GAME), .IN(IN),
        .IN_VALID(IN_VALID), .RAND(RAND), .OUT(OUT), .OUT_ENA(OUT_ENA),
        .LOSE(LOSE), .WIN(WIN), .HS(HS), .SCORE(SCORE), .HISCORE(HISCORE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic next_rand(input int c);
        RAND = 2'(c);
        game_seq.push_back(c);
    endtask

    // Rising edge on START_GAME; returns in the ADD cycle.
    task automatic start(input int c);
        game_seq.delete();
        next_rand(c);
        START_GAME = 1'b1;
        tick();
        START_GAME = 1'b0;
    endtask

    // Called in the ADD cycle; checks every lamp of the playback.
    task automatic watch_round(input string name);
        int n;
        int cnt;
        int exp;
        foreach (game_seq[i]) exp_q.push_back(game_seq[i]);
        n = game_seq.size();
        for (int k = 0; k < n; k++) begin
            cnt = 0;
            while (!OUT_ENA && cnt < 50) begin
                tick();
                cnt++;
            end
            chk($sformatf("%s_dark%0d", name, k), cnt, (k == 0) ? GT + 1 : GT);
            exp = exp_q.pop_front();
            chk($sformatf("%s_lamp%0d", name, k), OUT, exp);
            cnt = 0;
            while (OUT_ENA && cnt < 50) begin
                tick();
                cnt++;
            end
            chk($sformatf("%s_lit%0d", name, k), cnt, ST);
        end
        exp_q.delete();
    endtask

    // One press; afterwards waits out any lamp activity (echo).
    task automatic press(input int c);
        int cnt;
        IN = 2'(c);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        cnt = 0;
        while (OUT_ENA && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        // Reset state
        repeat (2) tick();
        chk("rst_ena", OUT_ENA, 0);
        chk("rst_out", OUT, 0);
        chk("rst_lose", LOSE, 0);
        chk("rst_win", WIN, 0);
        chk("rst_hs", HS, 0);
        chk("rst_score", SCORE, 0);
        chk("rst_hi", HISCORE, 0);
        RST = 1'b0;
        tick();

        // Game 1: full win with sequence 2,0,3
        start(2);
        watch_round("g1r1");
        next_rand(0);
        press(2);
        chk("g1_score1", SCORE, 1);
        watch_round("g1r2");
        next_rand(3);
        press(2);
        press(0);
        chk("g1_score2", SCORE, 2);
        watch_round("g1r3");
        press(2);
        press(0);
        press(3);
        chk("g1_score3", SCORE, 3);
        chk("g1_win", WIN, 1);
        chk("g1_lose", LOSE, 0);
        chk("g1_hs", HS, 1);
        chk("g1_hi", HISCORE, 3);

        // Abort from WIN, then asynchronous reset in the middle of SHOW
        start(1);
        chk("abort_win", WIN, 0);
        cnt = 0;
        while (!OUT_ENA && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("mid_show", OUT_ENA, 1);
        RST = 1'b1;
        #1;
        chk("arst_ena", OUT_ENA, 0);
        chk("arst_out", OUT, 0);
        chk("arst_score", SCORE, 0);
        chk("arst_hi", HISCORE, 0);
        tick();
        RST = 1'b0;
        tick();

        // Game 2: wrong input in round 2
        start(2);
        watch_round("g2r1");
        next_rand(0);
        press(2);
        watch_round("g2r2");
        press(2);
        press(1);
        chk("g2_lose", LOSE, 1);
        chk("g2_win", WIN, 0);
        chk("g2_score", SCORE, 1);
        chk("g2_hi", HISCORE, 1);
        chk("g2_hs", HS, 1);

        // Game 3: start from LOSE, lose at score 0
        start(1);
        chk("g3_lose_clr", LOSE, 0);
        chk("g3_hs_clr", HS, 0);
        chk("g3_score_clr", SCORE, 0);
        watch_round("g3r1");
        press(3);
        chk("g3_lose", LOSE, 1);
        chk("g3_hs", HS, 0);
        chk("g3_hi", HISCORE, 1);
        chk("g3_score", SCORE, 0);

        // Game 4: press in the timeout cycle survives, then a silent timeout
        start(3);
        watch_round("g4r1");
        next_rand(1);
        press(3);
        watch_round("g4r2");
        repeat (TT - 1) tick();
        press(3);
        chk("tmo_edge_press", LOSE, 0);
        cnt = 0;
        while (!LOSE && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("tmo_cycles", cnt, TT);
        chk("tmo_score", SCORE, 1);
        chk("tmo_hs", HS, 0);
        chk("tmo_hi", HISCORE, 1);

        // Game 5: start edge and a correct press in the same cycle
        start(2);
        watch_round("g5r1");
        game_seq.delete();
        next_rand(0);
        START_GAME = 1'b1;
        IN = 2'd2;
        IN_VALID = 1'b1;
        tick();
        START_GAME = 1'b0;
        IN_VALID = 1'b0;
        chk("sim_score", SCORE, 0);
        chk("sim_lose", LOSE, 0);
        watch_round("g5new");
        next_rand(1);
`ifdef SIMON_ECHO_EN
        IN = 2'd0;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("echo_ena", OUT_ENA, 1);
        chk("echo_out", OUT, 0);
        cnt = 1;
        IN = 2'd3;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("echo_ignore", LOSE, 0);
        while (OUT_ENA && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("echo_dur", cnt, ST);
`else
        press(0);
        chk("noecho_ena", OUT_ENA, 0);
`endif
        chk("g5_score", SCORE, 1);
        chk("g5_lose", LOSE, 0);
        watch_round("g5r2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
